// File: rtl/audio_level_meter.sv
`default_nettype none
// ============================================================================
// audio_level_meter: windowed mean-magnitude LED meter with bar/dot display
// and peak hold.  Rev 1.0
// ============================================================================
module audio_level_meter #(
  parameter int SAMPLE_W  = 8,
  parameter int LOG2_WIN  = 8,
  parameter int NUM_LEDS  = 8,
  parameter int PEAK_HOLD = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sample_valid,
  input  logic signed [SAMPLE_W-1:0] sample,
  input  logic                       mode,
  input  logic                       peak_en,
  output logic [NUM_LEDS-1:0]        led,
  output logic [SAMPLE_W-1:0]        level,
  output logic                       level_valid
);

  localparam int ACC_W  = SAMPLE_W + LOG2_WIN;
  localparam int IDX_W  = $clog2(NUM_LEDS + 1);
  localparam int HOLD_W = (PEAK_HOLD < 1) ? 1 : $clog2(PEAK_HOLD + 1);
  localparam logic [LOG2_WIN-1:0] C_CNT_LAST = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_QUANT = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

  // Stage 1: magnitude
  logic [SAMPLE_W-1:0] sample_u;
  logic [SAMPLE_W-1:0] mag_d, mag_q;
  logic                mag_vld_d, mag_vld_q;

  // Stage 2: accumulate and window boundary
  logic [ACC_W-1:0]    acc_d, acc_q, acc_sum;
  logic [LOG2_WIN-1:0] cnt_d, cnt_q;
  logic [SAMPLE_W-1:0] mean_d, mean_q;
  logic                win_done;

  // Update FSM
  state_t              state_d, state_q;
  logic [IDX_W-1:0]    seg_n;
  logic [IDX_W-1:0]    n_d, n_q;
  logic [IDX_W-1:0]    p_d, p_q;
  logic [HOLD_W-1:0]   h_d, h_q;
  logic                mode_d, mode_q;
  logic                pk_d, pk_q;
  logic [NUM_LEDS-1:0] led_pat;
  logic [NUM_LEDS-1:0] led_d, led_q;
  logic [SAMPLE_W-1:0] level_d, level_q;
  logic                level_valid_d, level_valid_q;

  assign sample_u = sample;

  // Two's complement negate without saturation: the most negative value
  // wraps to 2^(SAMPLE_W-1), which is exactly its unsigned magnitude.
  always_comb begin
    mag_vld_d = sample_valid;
    mag_d     = mag_q;
    if (sample_valid) begin
      mag_d = sample_u[SAMPLE_W-1] ? (~sample_u + SAMPLE_W'(1)) : sample_u;
    end
  end

  always_comb begin
    acc_sum  = acc_q + ACC_W'(mag_q);
    win_done = mag_vld_q && (cnt_q == C_CNT_LAST);
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    mean_d   = mean_q;
    if (mag_vld_q) begin
      cnt_d = cnt_q + LOG2_WIN'(1);
      if (win_done) begin
        // Last sample is folded into the mean; next window starts from zero.
        acc_d  = '0;
        mean_d = acc_sum[ACC_W-1:LOG2_WIN];
      end else begin
        acc_d = acc_sum;
      end
    end
  end

  // Lowest segment always lit; each further segment doubles the threshold.
  always_comb begin
    seg_n = IDX_W'(1);
    for (int j = 1; j < NUM_LEDS; j++) begin
      if ((mean_q >> (SAMPLE_W - NUM_LEDS + j)) != '0) begin
        seg_n = seg_n + IDX_W'(1);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_LEDS; i++) begin
      if (mode_q) begin
        led_pat[i] = (i == NUM_LEDS - int'(n_q));
      end else begin
        led_pat[i] = (i >= NUM_LEDS - int'(n_q));
      end
      if (pk_q && (p_q != '0) && (i == NUM_LEDS - int'(p_q))) begin
        led_pat[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    n_d           = n_q;
    p_d           = p_q;
    h_d           = h_q;
    mode_d        = mode_q;
    pk_d          = pk_q;
    led_d         = led_q;
    level_d       = level_q;
    level_valid_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (win_done) begin
          state_d = ST_QUANT;
        end
      end
      ST_QUANT: begin
        n_d    = seg_n;
        mode_d = mode;
        pk_d   = peak_en;
        if (seg_n >= p_q) begin
          p_d = seg_n;
          h_d = HOLD_W'(PEAK_HOLD);
        end else if (h_q == '0) begin
          p_d = p_q - IDX_W'(1);
        end else begin
          h_d = h_q - HOLD_W'(1);
        end
        state_d = ST_SHOW;
      end
      ST_SHOW: begin
        led_d         = led_pat;
        level_d       = mean_q;
        level_valid_d = 1'b1;
        state_d       = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mag_q         <= '0;
      mag_vld_q     <= 1'b0;
      acc_q         <= '0;
      cnt_q         <= '0;
      mean_q        <= '0;
      state_q       <= ST_IDLE;
      n_q           <= '0;
      p_q           <= '0;
      h_q           <= '0;
      mode_q        <= 1'b0;
      pk_q          <= 1'b0;
      led_q         <= '0;
      level_q       <= '0;
      level_valid_q <= 1'b0;
    end else begin
      mag_q         <= mag_d;
      mag_vld_q     <= mag_vld_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      mean_q        <= mean_d;
      state_q       <= state_d;
      n_q           <= n_d;
      p_q           <= p_d;
      h_q           <= h_d;
      mode_q        <= mode_d;
      pk_q          <= pk_d;
      led_q         <= led_d;
      level_q       <= level_d;
      level_valid_q <= level_valid_d;
    end
  end

  assign led         = led_q;
  assign level       = level_q;
  assign level_valid = level_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_audio_level_meter.sv
`default_nettype none
// ============================================================================
// tb_audio_level_meter: randomized and directed stimulus against a
// window-level reference model of the meter.  Rev 1.0
// ============================================================================
module tb_audio_level_meter;

  localparam int SW  = 8;
  localparam int LW  = 8;
  localparam int NL  = 8;
  localparam int PH  = 4;
  localparam int WIN = 1 << LW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          sample_valid = 1'b0;
  logic [SW-1:0] sample = '0;
  logic          mode = 1'b0;
  logic          peak_en = 1'b0;
  logic [NL-1:0] led;
  logic [SW-1:0] level;
  logic          level_valid;

  audio_level_meter #(
    .SAMPLE_W (SW),
    .LOG2_WIN (LW),
    .NUM_LEDS (NL),
    .PEAK_HOLD(PH)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .sample_valid(sample_valid),
    .sample      (sample),
    .mode        (mode),
    .peak_en     (peak_en),
    .led         (led),
    .level       (level),
    .level_valid (level_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            lvl;
    logic [NL-1:0] pat;
    longint        cyc;
  } exp_t;

  exp_t          exp_q[$];
  longint        cyc = 0;
  logic          rst_d1 = 1'b0;
  int            n_tests = 0;
  int            n_fail = 0;
  int            pulse_cnt = 0;
  int            win_sum = 0;
  int            win_cnt = 0;
  int            pm = 0;
  int            hm = 0;
  int            held_level = 0;
  logic [NL-1:0] held_led = '0;

  task automatic check_value(input string tag, input longint obs, input longint exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int seg_count(input int mean);
    int n;
    n = 1;
    for (int j = 1; j < NL; j++) begin
      if (mean >= (1 << (SW - NL + j))) n++;
    end
    return n;
  endfunction

  function automatic logic [NL-1:0] led_model(input int n, input int p, input bit md, input bit pk);
    logic [NL-1:0] v;
    v = '0;
    if (md) v[NL-n] = 1'b1;
    else for (int k = NL - n; k < NL; k++) v[k] = 1'b1;
    if (pk && p >= 1) v[NL-p] = 1'b1;
    return v;
  endfunction

  // Reference: whole-window arithmetic mean and peak rules.
  task automatic model_accept(input int mag, input longint drive_cyc);
    int   mean;
    int   n;
    exp_t e;
    win_sum += mag;
    win_cnt++;
    if (win_cnt == WIN) begin
      mean = win_sum / WIN;
      n    = seg_count(mean);
      if (n >= pm) begin
        pm = n;
        hm = PH;
      end else if (hm == 0) begin
        pm--;
      end else begin
        hm--;
      end
      e.lvl = mean;
      e.pat = led_model(n, pm, mode, peak_en);
      e.cyc = drive_cyc + 4;
      exp_q.push_back(e);
      win_sum = 0;
      win_cnt = 0;
    end
  endtask

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    rst_d1 <= reset;
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_d1) begin
      check_value("rst_led", longint'(led), 0);
      check_value("rst_level", longint'(level), 0);
      check_value("rst_level_valid", longint'(level_valid), 0);
    end else if (!reset) begin
      if (level_valid) begin
        pulse_cnt++;
        if (exp_q.size() == 0) begin
          check_value("spurious_pulse", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check_value("level", longint'(level), longint'(e.lvl));
          check_value("led", longint'(led), longint'(e.pat));
          check_value("latency_cycle", cyc, e.cyc);
          held_level = e.lvl;
          held_led   = e.pat;
        end
      end else begin
        check_value("hold_level", longint'(level), longint'(held_level));
        check_value("hold_led", longint'(led), longint'(held_led));
        if (exp_q.size() > 0 && cyc >= exp_q[0].cyc) begin
          check_value("missing_pulse", 0, 1);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic drive_sample(input int s);
    @(posedge clk);
    #1;
    sample_valid = 1'b1;
    sample       = SW'(s);
    model_accept((s < 0) ? -s : s, cyc);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      sample_valid = 1'b0;
      sample       = SW'($urandom);
    end
  endtask

  // Mode toggles while no update is in flight must not disturb the display.
  task automatic idle_toggle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      sample_valid = 1'b0;
      sample       = SW'($urandom);
      mode         = 1'($urandom);
      peak_en      = 1'($urandom);
    end
  endtask

  task automatic settle();
    idle(3);
    idle_toggle(3);
  endtask

  task automatic run_window(input int count, input int val, input bit rnd,
                            input bit md, input bit pk, input int gmin, input int gmax);
    mode    = md;
    peak_en = pk;
    for (int i = 0; i < count; i++) begin
      drive_sample(rnd ? (int'($urandom_range(0, 255)) - 128) : val);
      if (gmax > 0) idle(int'($urandom_range(gmin, gmax)));
    end
  endtask

  task automatic apply_reset(input int cycles);
    @(posedge clk);
    #1;
    reset        = 1'b1;
    sample_valid = 1'b1;
    sample       = SW'($urandom);
    win_sum      = 0;
    win_cnt      = 0;
    pm           = 0;
    hm           = 0;
    held_level   = 0;
    held_led     = '0;
    exp_q.delete();
    repeat (cycles - 1) begin
      @(posedge clk);
      #1;
      sample_valid = 1'($urandom);
      sample       = SW'($urandom);
    end
    @(posedge clk);
    #1;
    reset        = 1'b0;
    sample_valid = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  pc0;
    bit  md, pk;
    bit  settled;
    apply_reset(3);
    idle(2);

    // Mean 64 back-to-back
    run_window(WIN, 64, 1'b0, 1'b0, 1'b0, 0, 0);
    settle();
    check_value("bar64_level", longint'(level), 64);
    check_value("bar64_led", longint'(led), 'hFE);

    // Most negative sample
    run_window(WIN, -128, 1'b0, 1'b0, 1'b0, 0, 0);
    settle();
    check_value("neg128_level", longint'(level), 128);
    check_value("neg128_led", longint'(led), 'hFF);

    run_window(WIN, 16, 1'b0, 1'b1, 1'b0, 0, 0);
    settle();
    check_value("dot16_led", longint'(led), 'h08);
    run_window(WIN, 16, 1'b0, 1'b0, 1'b0, 0, 0);
    settle();
    check_value("bar16_led", longint'(led), 'hF8);
    run_window(WIN, 0, 1'b0, 1'b1, 1'b0, 0, 0);
    settle();
    check_value("dot0_led", longint'(led), 'h80);
    run_window(WIN, 0, 1'b0, 1'b0, 1'b0, 0, 0);
    settle();
    check_value("bar0_led", longint'(led), 'h80);

    // Peak hold then decay
    apply_reset(2);
    run_window(WIN, 128, 1'b0, 1'b0, 1'b1, 0, 0);
    for (int w = 0; w < 6; w++) run_window(WIN, 0, 1'b0, 1'b0, 1'b1, 0, 0);
    settle();
    check_value("peak_decay_led", longint'(led), 'h84);

    // Reset mid-window discards the partial sum
    run_window(100, 127, 1'b0, 1'b0, 1'b0, 0, 0);
    apply_reset(2);
    pc0 = pulse_cnt;
    run_window(WIN, 4, 1'b0, 1'b0, 1'b0, 0, 0);
    settle();
    check_value("midrst_pulses", longint'(pulse_cnt - pc0), 1);
    check_value("midrst_level", longint'(level), 4);
    check_value("midrst_led", longint'(led), 'hE0);

    // One valid in three
    run_window(WIN, 64, 1'b0, 1'b0, 1'b0, 2, 2);
    settle();
    check_value("sparse_level", longint'(level), 64);
    check_value("sparse_led", longint'(led), 'hFE);

    // Reset landing on the QUANT edge suppresses the update
    pc0 = pulse_cnt;
    run_window(WIN, 100, 1'b0, 1'b0, 1'b0, 0, 0);
    idle(1);
    apply_reset(2);
    idle(6);
    check_value("quant_rst_pulses", longint'(pulse_cnt - pc0), 0);
    check_value("quant_rst_level", longint'(level), 0);

    // Randomized windows of arbitrary length and density
    md = 1'b0;
    pk = 1'b1;
    settled = 1'b1;
    for (int r = 0; r < 14; r++) begin
      if (settled) begin
        md = 1'($urandom);
        pk = 1'($urandom);
      end
      run_window(int'($urandom_range(40, 420)), 0, 1'b1, md, pk, 0, int'($urandom_range(0, 2)));
      settled = 1'($urandom);
      if (settled) settle();
    end
    settle();
    idle(10);
    check_value("drain_pending", longint'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/audio_level_meter.md
AUDIO_LEVEL_METER -- requirements
Module: audio_level_meter

Interface
REQ-001 Parameter SAMPLE_W, default 8: sample width in bits, two's complement signed.
REQ-002 Parameter LOG2_WIN, default 8: averaging window is 2^LOG2_WIN accepted samples.
REQ-003 Parameter NUM_LEDS, default 8: LED segment count; SHALL satisfy 2 <= NUM_LEDS <= SAMPLE_W+1.
REQ-004 Parameter PEAK_HOLD, default 4: number of window updates a peak segment is held before decay.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 sample_valid  in  1  one-cycle qualifier; sample accepted on every cycle it is high, back-to-back allowed.
REQ-008 sample  in  SAMPLE_W  signed audio sample.
REQ-009 mode  in  1  0 = bar display, 1 = dot display.
REQ-010 peak_en  in  1  1 = overlay peak-hold segment on led.
REQ-011 led  out  NUM_LEDS  meter segments; led[NUM_LEDS-1] is the lowest segment, segments fill toward led[0].
REQ-012 level  out  SAMPLE_W  unsigned mean magnitude of last completed window.
REQ-013 level_valid  out  1  one-cycle pulse when led/level update.

Function
REQ-014 Stage 1 SHALL register magnitude |sample| as SAMPLE_W-bit unsigned; -2^(SAMPLE_W-1) maps to 2^(SAMPLE_W-1) (no saturation, no overflow).
REQ-015 Stage 2 SHALL add magnitude into an accumulator of SAMPLE_W+LOG2_WIN bits; overflow is impossible by construction.
REQ-016 Window counter SHALL count accepted samples 0..2^LOG2_WIN-1 and wrap to 0 after the last sample of a window.
REQ-017 On the last sample's accumulate, mean = (acc + magnitude) >> LOG2_WIN SHALL be latched and the accumulator SHALL restart at 0 for the next window; no sample is dropped or double-counted at the boundary, including with sample_valid high every cycle.
REQ-018 Segment count n SHALL be 1 + number of j in 1..NUM_LEDS-1 with mean >= 2^(SAMPLE_W-NUM_LEDS+j); n ranges 1..NUM_LEDS, so the lowest segment is always lit.
REQ-019 Bar mode: led bits NUM_LEDS-1 down to NUM_LEDS-n SHALL be 1, the rest 0.
REQ-020 Dot mode: only led[NUM_LEDS-n] SHALL be 1.
REQ-021 Peak index p (0..NUM_LEDS) and hold counter h SHALL update once per window: if n >= p then p <= n, h <= PEAK_HOLD; else if h == 0 then p <= p-1; else h <= h-1.
REQ-022 If peak_en = 1 and p >= 1, led[NUM_LEDS-p] SHALL additionally be 1; peak tracking SHALL continue while peak_en = 0.
REQ-023 Update FSM states: IDLE (wait for mean latch) -> QUANT (compute n, update p/h) -> SHOW (register led, level, pulse level_valid) -> IDLE; each state one cycle.
REQ-024 Latency: level/led/level_valid SHALL update 4 cycles after the cycle carrying the window's last sample_valid (abs, accumulate/latch, QUANT, SHOW).
REQ-025 mode and peak_en SHALL be sampled in QUANT only; changes between updates do not alter led.
REQ-026 Window length 2^LOG2_WIN >= 4 guarantees the FSM returns to IDLE before the next mean latch; led and level SHALL hold between updates.

Reset
REQ-027 While reset is high: led = 0, level = 0, level_valid = 0, accumulator = 0, window counter = 0, p = 0, h = 0, FSM = IDLE, pipeline valids cleared; sample_valid ignored.
REQ-028 Reset mid-window SHALL discard the partial sum; the first accepted sample after reset falls starts a new window.
REQ-029 Reset during QUANT/SHOW SHALL suppress that update; no level_valid pulse is issued.

Verification (defaults: SAMPLE_W=8, LOG2_WIN=8, NUM_LEDS=8, PEAK_HOLD=4)
REQ-030 256 back-to-back samples of +64, mode=0 -> level=64, led=1111_1110, single level_valid pulse 4 cycles after last sample.
REQ-031 256 samples of -128 -> level=128, led=1111_1111; no accumulator overflow.
REQ-032 mode=1, 256 samples of 16 -> led=0000_1000; mode=0 same data -> led=1111_1000; all-zero window -> led=1000_0000 in both modes.
REQ-033 peak_en=1, one window of 128 then windows of 0 -> updates 2-5 led=1000_0001, update 6 led=1000_0010, update 7 led=1000_0100.
REQ-034 100 samples of 127, reset pulse, then 256 samples of 4 -> exactly one level_valid, level=4, led=1110_0000.
REQ-035 Scenario REQ-030 repeated with sample_valid high one cycle in three -> identical level and led.
